// File: rtl/fetch_buffer_if.sv
// Bundle of the fetch_buffer data-path signals: redirect input, instruction-memory
// req/ack bus and the valid/ready queue output towards decode.
interface fetch_buffer_if #(
   parameter int XLEN = 32
);
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] PC_out;
   logic [XLEN-1:0] IR_out;

   // master: the fetch buffer itself
   modport master (
      input  redirect, redirect_pc, imem_ack, imem_data, out_ready,
      output imem_req, imem_addr, out_valid, PC_out, IR_out
   );

   // slave: the surrounding memory, ALU and decode
   modport slave (
      output redirect, redirect_pc, imem_ack, imem_data, out_ready,
      input  imem_req, imem_addr, out_valid, PC_out, IR_out
   );
endinterface

// File: rtl/fetch_buffer.sv
// Sequential-PC instruction fetcher with a DEPTH-entry {PC, IR} queue towards decode.
// A redirect flushes the queue and restarts fetch, dropping any in-flight response.
module fetch_buffer #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic              clk,
   input logic              rst,
   fetch_buffer_if.master   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

   state_t          state_q;
   logic [XLEN-1:0] fetch_pc_q;
   logic [XLEN-1:0] addr_q;
   logic            req_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic [XLEN-1:0] pc_mem_q [DEPTH];
   logic [XLEN-1:0] ir_mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic [XLEN-1:0] target_pc;
   logic [XLEN-1:0] fetch_pc_inc;

   // Only a response to a live request is queued; acks while idle are ignored.
   assign push         = (state_q == S_WAIT) && bus.imem_ack && !bus.redirect;
   assign pop          = (count_q != '0) && bus.out_ready && !bus.redirect;
   assign count_d      = count_q + CW'(push) - CW'(pop);
   assign target_pc    = bus.redirect_pc & ~XLEN'(3);
   assign fetch_pc_inc = fetch_pc_q + XLEN'(4);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= '0;
         req_q      <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else if (bus.redirect) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fetch_pc_q <= target_pc;
         // An unanswered request must stay on the bus until its ack, then be dropped.
         if ((state_q != S_IDLE) && !bus.imem_ack) begin
            state_q <= S_DISCARD;
         end else begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
            addr_q  <= target_pc;
         end
      end else begin
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case (state_q)
            S_IDLE: begin
               if (count_q < FULL) begin
                  state_q <= S_WAIT;
                  req_q   <= 1'b1;
                  addr_q  <= fetch_pc_q;
               end
            end
            S_WAIT: begin
               if (bus.imem_ack) begin
                  fetch_pc_q <= fetch_pc_inc;
                  // With one outstanding, count_d < FULL guarantees a slot for the next response.
                  if (count_d < FULL) begin
                     addr_q <= fetch_pc_inc;
                  end else begin
                     req_q   <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_DISCARD: begin
               if (bus.imem_ack) begin
                  state_q <= S_WAIT;
                  addr_q  <= fetch_pc_q;
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i] <= '0;
            ir_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q] <= addr_q;
         ir_mem_q[wr_ptr_q] <= bus.imem_data;
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.PC_out    = pc_mem_q[rd_ptr_q];
   assign bus.IR_out    = ir_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus a random phase,
// compared every cycle against a queue-based reference of the fetch stream.
module tb_fetch_buffer;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;

   fetch_buffer_if #(.XLEN(XLEN)) bus ();

   fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference: decoded queue contents plus the one outstanding memory request.
   logic [31:0] q_pc[$];
   logic [31:0] q_ir[$];
   logic [31:0] m_fetch;
   logic [31:0] m_addr;
   bit          m_req;
   bit          m_disc;
   int          wcnt;
   int          wait_lat;
   bit          rand_wait;
   bit          rdy;
   bit          force_ack;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q_pc.delete();
      q_ir.delete();
      m_fetch = 32'h0;
      m_addr  = 32'h0;
      m_req   = 1'b0;
      m_disc  = 1'b0;
      wcnt    = 0;
   endtask

   task automatic model_step(input bit ack, input bit redir, input bit rd, input logic [31:0] rpc);
      logic [31:0] tgt;
      int n;
      if (redir) begin
         tgt = {rpc[31:2], 2'b00};
         q_pc.delete();
         q_ir.delete();
         m_fetch = tgt;
         if (m_req && !ack) begin
            m_disc = 1'b1;
         end else begin
            m_req  = 1'b1;
            m_addr = tgt;
            m_disc = 1'b0;
         end
      end else begin
         n = q_pc.size();
         if (n != 0 && rd) begin
            void'(q_pc.pop_front());
            void'(q_ir.pop_front());
         end
         if (m_req && ack) begin
            if (m_disc) begin
               m_disc = 1'b0;
               m_addr = m_fetch;
            end else begin
               q_pc.push_back(m_addr);
               q_ir.push_back(mem(m_addr));
               m_fetch = m_fetch + 32'd4;
               if (q_pc.size() < DEPTH) m_addr = m_fetch;
               else m_req = 1'b0;
            end
         end else if (!m_req && n < DEPTH) begin
            m_req  = 1'b1;
            m_addr = m_fetch;
         end
      end
   endtask

   task automatic check_outputs(input string ph);
      chk({ph, "/req"},   32'(bus.imem_req), 32'(m_req));
      chk({ph, "/addr"},  bus.imem_addr, m_addr);
      chk({ph, "/valid"}, 32'(bus.out_valid), 32'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
         chk({ph, "/pc"}, bus.PC_out, q_pc[0]);
         chk({ph, "/ir"}, bus.IR_out, q_ir[0]);
      end
   endtask

   task automatic check_zero(input string ph);
      chk({ph, "/req0"},   32'(bus.imem_req), 32'h0);
      chk({ph, "/addr0"},  bus.imem_addr, 32'h0);
      chk({ph, "/valid0"}, 32'(bus.out_valid), 32'h0);
      chk({ph, "/pc0"},    bus.PC_out, 32'h0);
      chk({ph, "/ir0"},    bus.IR_out, 32'h0);
   endtask

   // One clock cycle: check at the negedge, drive inputs, advance the reference.
   task automatic cycle(input string ph, input bit redir, input logic [31:0] rpc);
      bit ack;
      check_outputs(ph);
      ack = force_ack || (m_req && (wcnt >= wait_lat));
      bus.imem_ack    = ack;
      bus.imem_data   = ack ? mem(bus.imem_addr) : $urandom;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      bus.out_ready   = rdy;
      if (ack) begin
         wcnt = 0;
         if (rand_wait) wait_lat = $urandom_range(0, 2);
      end else if (m_req) begin
         wcnt++;
      end
      model_step(ack, redir, rdy, rpc);
      @(posedge clk);
      @(negedge clk);
      if (q_pc.size() != 0 || bus.out_valid)
         $display("%s: req=%0b addr=%h valid=%0b pc=%h ir=%h", ph, bus.imem_req,
                  bus.imem_addr, bus.out_valid, bus.PC_out, bus.IR_out);
   endtask

   initial begin
      rst             = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.imem_ack    = 1'b0;
      bus.imem_data   = '0;
      bus.out_ready   = 1'b0;
      wait_lat  = 0;
      rand_wait = 1'b0;
      rdy       = 1'b1;
      force_ack = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // Zero-wait memory, decode always ready.
      repeat (20) cycle("stream", 1'b0, '0);

      // Decode stalls: queue fills to DEPTH and fetch stops, then drains in order.
      rdy = 1'b0;
      repeat (10) cycle("stall", 1'b0, '0);
      chk("stall/full_req", 32'(bus.imem_req), 32'h0);
      rdy = 1'b1;
      repeat (12) cycle("drain", 1'b0, '0);

      // Redirect while a wait-stated request is outstanding.
      wait_lat = 3;
      for (int i = 0; i < 30 && !(m_req && wcnt == 1); i++) cycle("sync", 1'b0, '0);
      chk("discard/sync_req", 32'(bus.imem_req), 32'h1);
      cycle("redir_wait", 1'b1, 32'h100);
      repeat (15) cycle("after_discard", 1'b0, '0);

      // Redirect on a full queue with a pop, target with low bits set.
      wait_lat = 0;
      rdy = 1'b0;
      repeat (6) cycle("fill", 1'b0, '0);
      rdy = 1'b1;
      cycle("redir_full", 1'b1, 32'h103);
      cycle("redir_full", 1'b0, '0);
      chk("redir_full/pc_target", bus.PC_out, 32'h100);
      repeat (6) cycle("restart", 1'b0, '0);

      // Redirect coincident with a zero-wait ack.
      cycle("redir_ack", 1'b1, 32'h200);
      repeat (6) cycle("restart2", 1'b0, '0);

      // Address wrap.
      cycle("wrap", 1'b1, 32'hFFFFFFF8);
      repeat (6) cycle("wrap", 1'b0, '0);

      // Random latencies, stalls and redirects.
      rand_wait = 1'b1;
      for (int i = 0; i < 400; i++) begin
         rdy = ($urandom_range(0, 3) != 0);
         cycle("rand", ($urandom_range(0, 19) == 0), $urandom);
      end
      rand_wait = 1'b0;

      // Asynchronous reset in the middle of a wait-stated request.
      wait_lat = 3;
      rdy = 1'b1;
      for (int i = 0; i < 30 && !(m_req && wcnt == 1); i++) cycle("pre_rst", 1'b0, '0);
      chk("rst/sync_req", 32'(bus.imem_req), 32'h1);
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      wait_lat  = 0;
      force_ack = 1'b1;
      cycle("stale_ack", 1'b0, '0);
      force_ack = 1'b0;
      repeat (10) cycle("post_rst", 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
